// File: rtl/fixed_point_pkg.sv
// fixed_point_pkg: Booth digit codes, rounding modes, FSM states and saturation limits for the fixed-point library
package fixed_point_pkg;
  typedef enum logic [2:0] {ZERO, PLUS_A, PLUS_2A, MINUS_A, MINUS_2A} booth_digit_e;
  typedef enum logic [1:0] {IDLE, RUN, DONE, HOLD} mul_state_e;
  localparam logic RND_TRUNC   = 1'b0;
  localparam logic RND_HALF_UP = 1'b1;
  function automatic booth_digit_e booth_decode(input logic [2:0] w);
    case (w)
      3'b001, 3'b010: return PLUS_A;
      3'b011:         return PLUS_2A;
      3'b100:         return MINUS_2A;
      3'b101, 3'b110: return MINUS_A;
      default:        return ZERO;
    endcase
  endfunction
  function automatic longint sat_max(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction
  function automatic longint sat_min(input int w);
    return -(longint'(1) << (w - 1));
  endfunction
endpackage

// File: rtl/booth_digit_select.sv
// booth_digit_select: window_i (3-bit Booth window), a_i (A sign-extended by 2 bits) -> pp_o partial product 0/+-A/+-2A
module booth_digit_select
  import fixed_point_pkg::*;
#(
  parameter int W = 18
) (
  input  logic        [2:0]   window_i,
  input  logic signed [W-1:0] a_i,
  output logic signed [W-1:0] pp_o
);
  booth_digit_e d;
  always_comb begin
    d = booth_decode(window_i);
    pp_o = d == PLUS_A   ? a_i :
           d == PLUS_2A  ? a_i <<< 1 :
           d == MINUS_A  ? -a_i :
           d == MINUS_2A ? -(a_i <<< 1) : '0;
  end
endmodule

// File: rtl/multiplier_booth_radix4_param.sv
// multiplier_booth_radix4_param: sequential radix-4 Booth Q-format multiplier; in clk/rst/A/B/start/round_mode, out result/overflow_flag/finish/busy
module multiplier_booth_radix4_param
  import fixed_point_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             start,
  input  logic             round_mode,
  output logic [WIDTH-1:0] result,
  output logic             overflow_flag,
  output logic             finish,
  output logic             busy
);
  localparam int AW = 2 * WIDTH + 2;
  localparam int PW = WIDTH + 2;
  localparam int CW = $clog2(WIDTH / 2);
  localparam logic signed [AW-1:0] RND_INC = (FRAC > 0) ? (AW'(1) << ((FRAC > 0) ? FRAC - 1 : 0)) : '0;
  localparam logic signed [AW-1:0] MAX_S = AW'(sat_max(WIDTH));
  localparam logic signed [AW-1:0] MIN_S = AW'(sat_min(WIDTH));
  mul_state_e state_q, state_d;
  logic signed [WIDTH-1:0] a_q;
  logic [WIDTH:0] b_q;
  logic rnd_q;
  logic [CW-1:0] cnt_q;
  logic signed [AW-1:0] acc_q;
  logic [WIDTH-1:0] result_q, res_d;
  logic ovf_q, ovf_d;
  logic accept, last;
  logic signed [PW-1:0] pp;
  logic signed [AW-1:0] rounded, shifted;
  booth_digit_select #(.W(PW)) u_sel (
    .window_i(b_q[2:0]),
    .a_i     ({{2{a_q[WIDTH-1]}}, a_q}),
    .pp_o    (pp)
  );
  always_ff @(posedge clk)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  always_comb begin
    accept = (state_q == IDLE || state_q == HOLD) && start;
    last = cnt_q == CW'(WIDTH / 2 - 1);
    state_d = accept ? RUN :
              state_q == RUN ? (last ? DONE : RUN) :
              state_q == DONE ? HOLD : state_q;
  end
  always_comb begin
    rounded = acc_q + ((rnd_q == RND_HALF_UP) ? RND_INC : '0);
    shifted = rounded >>> FRAC;
    ovf_d = shifted > MAX_S || shifted < MIN_S;
    res_d = shifted > MAX_S ? MAX_S[WIDTH-1:0] :
            shifted < MIN_S ? MIN_S[WIDTH-1:0] : shifted[WIDTH-1:0];
  end
  // b_q carries the implicit bit -1 in its LSB and shifts two places per digit
  always_ff @(posedge clk)
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      rnd_q <= RND_TRUNC;
      cnt_q <= '0;
      acc_q <= '0;
      result_q <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      a_q <= A;
      b_q <= {B, 1'b0};
      rnd_q <= round_mode;
      cnt_q <= '0;
      acc_q <= '0;
    end else if (state_q == RUN) begin
      acc_q <= acc_q + (AW'(pp) <<< {cnt_q, 1'b0});
      b_q <= b_q >> 2;
      cnt_q <= cnt_q + 1'b1;
    end else if (state_q == DONE) begin
      result_q <= res_d;
      ovf_q <= ovf_d;
    end
  always_comb begin
    finish = state_q == HOLD;
    busy = state_q == RUN || state_q == DONE;
    result = result_q;
    overflow_flag = ovf_q;
  end
endmodule

// File: tb/tb_multiplier_booth_radix4_param.sv
// tb_multiplier_booth_radix4_param: random and directed checks of the Booth multiplier against an arithmetic model
module tb_multiplier_booth_radix4_param;
  localparam int W = 16;
  localparam int F = 10;
  localparam int LAT = W / 2 + 1;
  localparam longint MAXV = (longint'(1) << (W - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (W - 1));
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] A = '0, B = '0;
  logic start = 1'b0, round_mode = 1'b0;
  logic [W-1:0] result;
  logic overflow_flag, finish, busy;
  int checks = 0, errors = 0;
  int n = 0, due = 0;
  bit act = 0, done_v = 0, ready = 0;
  logic [W-1:0] er = '0, nr = '0;
  logic eo = 1'b0, no = 1'b0;
  logic [W-1:0] corners [4] = '{16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF};
  multiplier_booth_radix4_param #(.WIDTH(W), .FRAC(F)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .start(start), .round_mode(round_mode),
    .result(result), .overflow_flag(overflow_flag), .finish(finish), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic r,
                                output logic [W-1:0] res, output logic o);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    if (r && F > 0) p = p + (longint'(1) << (F - 1));
    p = p >>> F;
    o = (p > MAXV) || (p < MINV);
    res = p > MAXV ? W'(MAXV) : p < MINV ? W'(MINV) : W'(p);
  endfunction
  always @(posedge clk) begin
    n++;
    if (rst) begin
      act = 0;
      done_v = 0;
      ready = 1;
    end else if (start && !(act && n <= due)) begin
      act = 1;
      due = n + LAT;
      done_v = 0;
      model(A, B, round_mode, nr, no);
    end else if (act && n == due) begin
      done_v = 1;
      er = nr;
      eo = no;
    end
  end
  always @(negedge clk)
    if (ready) begin
      chk("busy", 32'(busy), 32'(act && n < due));
      chk("finish", 32'(finish), 32'(done_v));
      if (done_v) begin
        chk("result", 32'(result), 32'(er));
        chk("overflow", 32'(overflow_flag), 32'(eo));
      end
    end
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic r);
    @(negedge clk);
    A = a;
    B = b;
    round_mode = r;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic await_finish(output int k);
    k = 0;
    while (finish !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
  endtask
  task automatic op(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input logic r,
                    input logic [W-1:0] exp_r, input logic exp_o);
    int k;
    launch(a, b, r);
    await_finish(k);
    chk({name, "_latency"}, k, LAT);
    chk({name, "_result"}, 32'(result), 32'(exp_r));
    chk({name, "_ovf"}, 32'(overflow_flag), 32'(exp_o));
  endtask
  function automatic logic [W-1:0] pick();
    return ($urandom % 6 == 0) ? corners[$urandom % 4] : W'($urandom);
  endfunction
  initial begin
    logic [W-1:0] mr;
    logic mo;
    int k, fin_cnt;
    model(16'h0600, 16'h0800, 1'b0, mr, mo);
    chk("model_mul", 32'(mr), 32'h0C00);
    model(16'h8000, 16'h8000, 1'b0, mr, mo);
    chk("model_sat", 32'({mo, mr}), 32'h17FFF);
    model(16'hFFFF, 16'h0200, 1'b1, mr, mo);
    chk("model_round", 32'(mr), 32'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_result", 32'(result), 0);
    chk("reset_flags", 32'({overflow_flag, finish, busy}), 0);
    op("pos", 16'h0600, 16'h0800, 1'b0, 16'h0C00, 1'b0);
    op("neg", 16'hFA00, 16'h0800, 1'b0, 16'hF400, 1'b0);
    op("zero", 16'h0000, 16'h7FFF, 1'b0, 16'h0000, 1'b0);
    op("satp", 16'h5000, 16'h0800, 1'b0, 16'h7FFF, 1'b1);
    op("satn", 16'h5000, 16'hF800, 1'b0, 16'h8000, 1'b1);
    op("mneg", 16'h8000, 16'h8000, 1'b0, 16'h7FFF, 1'b1);
    op("tr_p", 16'h0001, 16'h0200, 1'b0, 16'h0000, 1'b0);
    op("rn_p", 16'h0001, 16'h0200, 1'b1, 16'h0001, 1'b0);
    op("tr_n", 16'hFFFF, 16'h0200, 1'b0, 16'hFFFF, 1'b0);
    op("rn_n", 16'hFFFF, 16'h0200, 1'b1, 16'h0000, 1'b0);
    op("rn_ovf", 16'h7FFF, 16'h0800, 1'b1, 16'h7FFF, 1'b1);
    launch(16'h0600, 16'h0800, 1'b0);
    repeat (2) @(negedge clk);
    A = 16'h5000;
    B = 16'hF800;
    round_mode = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    await_finish(k);
    chk("ignore_result", 32'(result), 32'h0C00);
    chk("ignore_ovf", 32'(overflow_flag), 0);
    @(negedge clk);
    A = 16'h0600;
    B = 16'h0800;
    round_mode = 1'b0;
    start = 1'b1;
    fin_cnt = 0;
    for (int i = 0; i < 4 * (LAT + 1); i++) begin
      @(negedge clk);
      fin_cnt += int'(finish);
    end
    start = 1'b0;
    chk("b2b_finish_cycles", fin_cnt, 4);
    await_finish(k);
    chk("b2b_drain", 32'(finish), 1);
    launch(16'h5000, 16'h0800, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_run_result", 32'(result), 0);
    chk("rst_run_flags", 32'({overflow_flag, finish, busy}), 0);
    op("after_rst", 16'h0600, 16'h0800, 1'b0, 16'h0C00, 1'b0);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      start = ($urandom % 3 == 0);
      A = pick();
      B = pick();
      round_mode = 1'($urandom);
      rst = ($urandom % 500 == 0);
    end
    start = 1'b0;
    rst = 1'b0;
    repeat (LAT + 3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
